// File: rtl/reg_mode_n.sv
// rtl/reg_mode_n.sv - WIDTH-bit register with load, shift, increment, decrement and negate modes
// Carry/overflow flags are registered alongside Q; QBAR and ZERO are decoded from Q.
module reg_mode_n #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QBAR,
  output logic             CO,
  output logic             OVF,
  output logic             ZERO
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SRL  = 3'b011;
  localparam logic [2:0] MODE_SRA  = 3'b100;
  localparam logic [2:0] MODE_INC  = 3'b101;
  localparam logic [2:0] MODE_DEC  = 3'b110;
  localparam logic [2:0] MODE_NEG  = 3'b111;

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next_q;
  logic             w_next_co;
  logic             w_next_ovf;
  logic             w_q_zero;

  assign w_q_zero = (r_q == '0);

  // Flags are derived from the pre-edge value; wrap cases are detected directly.
  always_comb begin
    w_next_q   = r_q;
    w_next_co  = r_co;
    w_next_ovf = r_ovf;
    case (MODE)
      MODE_HOLD: ;
      MODE_LOAD: begin
        w_next_q   = D;
        w_next_co  = 1'b0;
        w_next_ovf = 1'b0;
      end
      MODE_SHL: begin
        w_next_q   = {r_q[WIDTH-2:0], SIN};
        w_next_co  = r_q[WIDTH-1];
        w_next_ovf = 1'b0;
      end
      MODE_SRL: begin
        w_next_q   = {SIN, r_q[WIDTH-1:1]};
        w_next_co  = r_q[0];
        w_next_ovf = 1'b0;
      end
      MODE_SRA: begin
        w_next_q   = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_next_co  = r_q[0];
        w_next_ovf = 1'b0;
      end
      MODE_INC: begin
        w_next_q   = r_q + ONE;
        w_next_co  = (r_q == '1);
        w_next_ovf = (r_q == MAX_POS);
      end
      MODE_DEC: begin
        w_next_q   = r_q - ONE;
        w_next_co  = w_q_zero;
        w_next_ovf = (r_q == MIN_NEG);
      end
      MODE_NEG: begin
        w_next_q   = ~r_q + ONE;
        w_next_co  = w_q_zero;
        w_next_ovf = (r_q == MIN_NEG);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_q   <= RESET_VAL;
      r_co  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_next_q;
      r_co  <= w_next_co;
      r_ovf <= w_next_ovf;
    end
  end

  assign Q    = r_q;
  assign QBAR = ~r_q;
  assign CO   = r_co;
  assign OVF  = r_ovf;
  assign ZERO = w_q_zero;

endmodule

// File: tb/tb_reg_mode_n.sv
// tb/tb_reg_mode_n.sv - directed table, hand sequences and random run against an arithmetic model
module tb_reg_mode_n;

  logic        CLK;
  logic        RESET;
  logic [2:0]  MODE;
  logic [31:0] D;
  logic        SIN;
  logic [31:0] Q;
  logic [31:0] QBAR;
  logic        CO;
  logic        OVF;
  logic        ZERO;

  int n_checks = 0;
  int n_errors = 0;

  reg_mode_n #(.WIDTH(32), .RESET_VAL(32'h0)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .D(D), .SIN(SIN),
    .Q(Q), .QBAR(QBAR), .CO(CO), .OVF(OVF), .ZERO(ZERO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic        rst;
    logic [2:0]  mode;
    logic [31:0] d;
    logic        sin;
    logic [31:0] q;
    logic        co;
    logic        ovf;
  } vec_t;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SRL = 3'd3,
                         SRA = 3'd4, INC = 3'd5, DEC = 3'd6, NEG = 3'd7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [31:0] q, input logic co, input logic ovf);
    chk({tag, ".Q"}, Q, q);
    chk({tag, ".CO"}, {31'd0, CO}, {31'd0, co});
    chk({tag, ".OVF"}, {31'd0, OVF}, {31'd0, ovf});
    chk({tag, ".QBAR"}, QBAR, ~q);
    chk({tag, ".ZERO"}, {31'd0, ZERO}, {31'd0, (q == 32'd0)});
  endtask

  task automatic step(input logic rst, input logic [2:0] mode, input logic [31:0] d, input logic sin);
    @(negedge CLK);
    RESET = rst; MODE = mode; D = d; SIN = sin;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: unsigned/signed integer arithmetic on the register value.
  longint m_q;
  logic   m_co, m_ovf;
  localparam longint TWO32 = 64'h1_0000_0000;
  localparam longint TWO31 = 64'h8000_0000;

  function automatic longint sval(input longint u);
    return (u >= TWO31) ? u - TWO32 : u;
  endfunction

  task automatic model_step(input logic rst, input logic [2:0] mode, input logic [31:0] d, input logic sin);
    longint s;
    s = sval(m_q);
    if (!rst) begin
      m_q = 0; m_co = 0; m_ovf = 0;
    end else begin
      case (mode)
        HOLD: ;
        LOAD: begin m_q = longint'(d); m_co = 0; m_ovf = 0; end
        SHL:  begin m_co = (m_q >= TWO31); m_q = (m_q * 2 + longint'(sin)) % TWO32; m_ovf = 0; end
        SRL:  begin m_co = m_q[0]; m_q = m_q / 2 + (sin ? TWO31 : 0); m_ovf = 0; end
        SRA:  begin m_co = m_q[0]; m_q = m_q / 2 + ((m_q >= TWO31) ? TWO31 : 0); m_ovf = 0; end
        INC:  begin m_co = (m_q + 1 == TWO32); m_ovf = (s + 1 > TWO31 - 1); m_q = (m_q + 1) % TWO32; end
        DEC:  begin m_co = (m_q == 0); m_ovf = (s - 1 < -TWO31); m_q = (m_q + TWO32 - 1) % TWO32; end
        NEG:  begin m_co = (m_q == 0); m_ovf = (-s > TWO31 - 1); m_q = (TWO32 - m_q) % TWO32; end
        default: ;
      endcase
    end
  endtask

  vec_t vecs[$];

  initial begin
    RESET = 1'b1; MODE = HOLD; D = '0; SIN = 1'b0;

    vecs.push_back({1'b0, LOAD, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back({1'b1, INC,  32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0});
    vecs.push_back({1'b1, INC,  32'h0,         1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back({1'b1, LOAD, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back({1'b1, DEC,  32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back({1'b1, DEC,  32'h0,         1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1});
    vecs.push_back({1'b1, LOAD, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 1'b0});
    vecs.push_back({1'b1, SHL,  32'h0,         1'b1, 32'h0000_0003, 1'b1, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 1'b0});
    vecs.push_back({1'b1, SRA,  32'h0,         1'b0, 32'hC000_0000, 1'b1, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 1'b0});
    vecs.push_back({1'b1, SRL,  32'h0,         1'b0, 32'h4000_0000, 1'b1, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'h0000_0005, 1'b0, 32'h0000_0005, 1'b0, 1'b0});
    vecs.push_back({1'b1, NEG,  32'h0,         1'b0, 32'hFFFF_FFFB, 1'b0, 1'b0});
    vecs.push_back({1'b1, LOAD, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0});
    vecs.push_back({1'b1, NEG,  32'h0,         1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back({1'b1, LOAD, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0});
    vecs.push_back({1'b1, NEG,  32'h0,         1'b0, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back({1'b1, HOLD, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].mode, vecs[i].d, vecs[i].sin);
      expect_state($sformatf("vec%0d", i), vecs[i].q, vecs[i].co, vecs[i].ovf);
    end

    // INC sets CO, then three HOLD cycles must keep it.
    step(1'b1, LOAD, 32'hFFFF_FFFF, 1'b0);
    step(1'b1, INC, 32'h0, 1'b0);
    expect_state("hold_pre", 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, HOLD, 32'h5555_5555, 1'b1);
      expect_state($sformatf("hold%0d", i), 32'h0, 1'b1, 1'b0);
    end

    // Reset in the middle of an INC run, then INC resumes on the first released edge.
    step(1'b1, INC, 32'h0, 1'b0);
    step(1'b1, INC, 32'h0, 1'b0);
    expect_state("run2", 32'h2, 1'b0, 1'b0);
    step(1'b0, INC, 32'h0, 1'b0);
    expect_state("midrst", 32'h0, 1'b0, 1'b0);
    step(1'b1, INC, 32'h0, 1'b0);
    expect_state("postrst", 32'h1, 1'b0, 1'b0);

    // Glitches on RESET/MODE/D between edges must not disturb the register.
    step(1'b1, LOAD, 32'h0000_00A5, 1'b0);
    @(negedge CLK);
    MODE = HOLD;
    #1 RESET = 1'b0; MODE = LOAD; D = 32'h0;
    #1 RESET = 1'b1; MODE = HOLD; D = 32'hFFFF_FFFF;
    @(posedge CLK);
    #1;
    expect_state("glitch", 32'h0000_00A5, 1'b0, 1'b0);

    // Random run from a known reset state.
    step(1'b0, HOLD, 32'h0, 1'b0);
    m_q = 0; m_co = 0; m_ovf = 0;
    expect_state("rnd_rst", 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      logic        r_rst;
      logic [2:0]  r_mode;
      logic [31:0] r_d;
      logic        r_sin;
      r_rst  = ($urandom_range(0, 31) != 0);
      r_mode = 3'($urandom_range(0, 7));
      r_sin  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: r_d = 32'h0;
        1: r_d = 32'hFFFF_FFFF;
        2: r_d = 32'h7FFF_FFFF;
        3: r_d = 32'h8000_0000;
        default: r_d = $urandom;
      endcase
      model_step(r_rst, r_mode, r_d, r_sin);
      step(r_rst, r_mode, r_d, r_sin);
      expect_state($sformatf("rnd%0d", i), m_q[31:0], m_co, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
